eth_udp_flood_gen: RTL and testbench

//  Runtime-configurable UDP/DNS-response frame generator for 10G traffic emulation.

---
 rtl/eth_udp_flood_gen_pkg.sv | 86 ++++++++
 rtl/eth_udp_flood_gen_csum.sv | 24 ++
 rtl/eth_udp_flood_gen.sv | 165 ++++++++++++++++
 tb/tb_eth_udp_flood_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_udp_flood_gen_pkg.sv
// Shared types and helpers for the UDP/DNS-response flood generator.
package eth_udp_flood_gen_pkg;

  localparam int HDR_BEATS = 6;
  localparam int HDR_BYTES = 48;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPDEFTTL       = 8'd64;
  localparam logic [7:0]  IPPROTO_UDP    = 8'd17;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } eth_hdr_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] check;
    logic [31:0] saddr;
    logic [31:0] daddr;
  } ip_hdr_t;

  typedef struct packed {
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] len;
    logic [15:0] check;
  } udp_hdr_t;

  typedef struct packed {
    logic [15:0] id;
    logic        qr;
    logic [3:0]  opcode;
    logic        aa;
    logic        tc;
    logic        rd;
    logic        ra;
    logic [2:0]  z;
    logic [3:0]  rcode;
  } dns_hdr_t;

  // Field order is wire order: the first declared field lands in the MSBs.
  typedef struct packed {
    eth_hdr_t    eth;
    ip_hdr_t     ip;
    udp_hdr_t    udp;
    dns_hdr_t    dns;
    logic [15:0] pad;
  } hdr_fields_t;

  // raw[HDR_BEATS-1] holds the first eight wire bytes, MSB-first.
  typedef union packed {
    logic [HDR_BEATS-1:0][63:0] raw;
    hdr_fields_t                f;
  } hdr48_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CSUM,
    ST_SEND,
    ST_GAP
  } state_t;

  // Byte enables of the final beat, from the frame length modulo 8.
  function automatic logic [7:0] tkeep_last(input logic [2:0] len_mod8);
    return (len_mod8 == 3'd0) ? 8'hFF : ((8'h01 << len_mod8) - 8'h01);
  endfunction

  // Big-endian header chunk to AXIS lane order (first wire byte in [7:0]).
  function automatic logic [63:0] endian_conv64(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 8; i++) o[8*i +: 8] = d[8*(7-i) +: 8];
    return o;
  endfunction

endpackage

// File: rtl/eth_udp_flood_gen_csum.sv
// Combinational IPv4 header checksum: sum of ten 16-bit words, two folds, invert.
module ipv4_hdr_csum
  import eth_udp_flood_gen_pkg::*;
(
  input  ip_hdr_t     hdr,
  output logic [15:0] csum
);

  logic [159:0] words;
  logic [31:0]  sum;
  logic [16:0]  fold1;
  logic [15:0]  fold2;

  // ones'-complement accumulate; the caller supplies the header with check = 0
  always_comb begin
    words = hdr;
    sum   = '0;
    for (int i = 0; i < 10; i++) sum = sum + {16'h0000, words[16*i +: 16]};
    fold1 = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    fold2 = fold1[15:0] + {15'h0000, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/eth_udp_flood_gen.sv
// Runtime-configurable UDP/DNS-response frame generator on a 64-bit AXIS TX port.
module eth_udp_flood_gen
  import eth_udp_flood_gen_pkg::*;
#(
  parameter logic [47:0] ETH_DST   = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [47:0] ETH_SRC   = 48'h00_BB_00_BB_00_BB,
  parameter logic [31:0] IP_DADDR  = {8'd10, 8'd0, 8'd0, 8'd1},
  parameter logic [15:0] UDP_SPORT = 16'd53,
  parameter logic [15:0] LEN_MIN   = 16'd64,
  parameter logic [15:0] LEN_MAX   = 16'd1518,
  parameter int          IFG_W     = 28
) (
  input  logic             clk156,
  input  logic             sys_rst,
  input  logic             cfg_enable,
  input  logic [15:0]      cfg_frame_len,
  input  logic [IFG_W-1:0] cfg_ifg,
  input  logic [15:0]      cfg_dport_lo,
  input  logic [15:0]      cfg_dport_hi,
  input  logic [31:0]      cfg_saddr_base,
  input  logic [15:0]      cfg_saddr_count,
  input  logic             s_axis_tx_tready,
  output logic             s_axis_tx_tvalid,
  output logic [63:0]      s_axis_tx_tdata,
  output logic [7:0]       s_axis_tx_tkeep,
  output logic             s_axis_tx_tlast,
  output logic             s_axis_tx_tuser,
  output logic [31:0]      pkt_count
);

  localparam logic [IFG_W-1:0] IFG_ONE = IFG_W'(1);

  state_t           state, state_nxt;
  logic [7:0]       beat, nbeats_q, keep_last_q;
  logic [15:0]      len_clamped, len_q;
  logic [15:0]      dport_q, dport_nxt_q, dport_lo_q, dport_hi_q;
  logic [31:0]      saddr_q;
  logic [15:0]      sidx, scount_q;
  logic             first_q;
  logic [IFG_W-1:0] ifg_q, gap_cnt;
  logic [15:0]      csum_calc, csum_q;
  hdr48_t           hdr;
  ip_hdr_t          ip_nock;
  logic [2:0]       hdr_idx;
  logic             last_beat, beat_fire, frame_done;

  assign len_clamped = (cfg_frame_len < LEN_MIN) ? LEN_MIN :
                       (cfg_frame_len > LEN_MAX) ? LEN_MAX : cfg_frame_len;
  assign last_beat   = (beat == nbeats_q - 8'd1);
  assign beat_fire   = (state == ST_SEND) && s_axis_tx_tready;
  assign frame_done  = beat_fire && last_beat;

  // state register
  always_ff @(posedge clk156) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // next-state: idle -> prep -> csum -> send -> (gap) -> idle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cfg_enable) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_CSUM;
      ST_CSUM: state_nxt = ST_SEND;
      ST_SEND: if (frame_done) state_nxt = (ifg_q == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt + IFG_ONE == ifg_q) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // beat/gap counters, pool index and frame counter
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      beat      <= '0;
      gap_cnt   <= '0;
      first_q   <= 1'b1;
      sidx      <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        ST_PREP: begin
          beat    <= '0;
          first_q <= 1'b0;
        end
        ST_SEND: if (beat_fire) begin
          if (last_beat) begin
            beat      <= '0;
            gap_cnt   <= '0;
            pkt_count <= pkt_count + 32'd1;
            sidx      <= (sidx >= scount_q - 16'd1) ? 16'd0 : sidx + 16'd1;
          end else begin
            beat <= beat + 8'd1;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + IFG_ONE;
        default: ;
      endcase
    end
  end

  // per-frame configuration snapshot, checksum register and next dport
  always_ff @(posedge clk156) begin
    if (state == ST_PREP) begin
      len_q       <= len_clamped;
      nbeats_q    <= len_clamped[10:3] + {7'd0, |len_clamped[2:0]};
      keep_last_q <= tkeep_last(len_clamped[2:0]);
      ifg_q       <= cfg_ifg;
      dport_lo_q  <= cfg_dport_lo;
      dport_hi_q  <= cfg_dport_hi;
      dport_q     <= first_q ? cfg_dport_lo : dport_nxt_q;
      saddr_q     <= cfg_saddr_base + {16'h0000, sidx};
      scount_q    <= (cfg_saddr_count == 16'd0) ? 16'd1 : cfg_saddr_count;
    end
    if (state == ST_CSUM) csum_q <= csum_calc;
    if (frame_done)
      dport_nxt_q <= ((dport_lo_q > dport_hi_q) || (dport_q == dport_hi_q)) ?
                     dport_lo_q : dport_q + 16'd1;
  end

  // 48-byte header from the latched fields
  always_comb begin
    hdr                 = '0;
    hdr.f.eth.dst       = ETH_DST;
    hdr.f.eth.src       = ETH_SRC;
    hdr.f.eth.ethertype = ETHERTYPE_IPV4;
    hdr.f.ip.version    = 4'd4;
    hdr.f.ip.ihl        = 4'd5;
    hdr.f.ip.tot_len    = len_q - 16'd14;
    hdr.f.ip.ttl        = IPDEFTTL;
    hdr.f.ip.protocol   = IPPROTO_UDP;
    hdr.f.ip.check      = csum_q;
    hdr.f.ip.saddr      = saddr_q;
    hdr.f.ip.daddr      = IP_DADDR;
    hdr.f.udp.sport     = UDP_SPORT;
    hdr.f.udp.dport     = dport_q;
    hdr.f.udp.len       = len_q - 16'd34;
    hdr.f.dns.qr        = 1'b1;
  end

  // checksum is computed over the IP header with its check field zeroed
  always_comb begin
    ip_nock       = hdr.f.ip;
    ip_nock.check = 16'h0000;
  end

  ipv4_hdr_csum u_csum (
    .hdr  (ip_nock),
    .csum (csum_calc)
  );

  // AXIS beat outputs; all zero outside SEND
  always_comb begin
    hdr_idx          = 3'(HDR_BEATS - 1) - beat[2:0];
    s_axis_tx_tvalid = (state == ST_SEND);
    s_axis_tx_tlast  = s_axis_tx_tvalid && last_beat;
    s_axis_tx_tkeep  = s_axis_tx_tvalid ? (last_beat ? keep_last_q : 8'hFF) : 8'h00;
    s_axis_tx_tdata  = '0;
    if (s_axis_tx_tvalid && (beat < 8'(HDR_BEATS)))
      s_axis_tx_tdata = endian_conv64(hdr.raw[hdr_idx]);
  end

  assign s_axis_tx_tuser = 1'b0;

endmodule

// File: tb/tb_eth_udp_flood_gen.sv
// Directed/randomized bench for eth_udp_flood_gen with a byte-level frame model.
module tb_eth_udp_flood_gen;

  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_frame_len = 16'd64;
  logic [27:0] cfg_ifg = '0;
  logic [15:0] cfg_dport_lo = 16'd1000;
  logic [15:0] cfg_dport_hi = 16'd1000;
  logic [31:0] cfg_saddr_base = 32'hC0A8_0001;
  logic [15:0] cfg_saddr_count = 16'd1;
  logic        s_axis_tx_tready = 1'b1;
  logic        s_axis_tx_tvalid;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tuser;
  logic [31:0] pkt_count;

  always #5 clk156 = ~clk156;

  eth_udp_flood_gen dut (
    .clk156           (clk156),
    .sys_rst          (sys_rst),
    .cfg_enable       (cfg_enable),
    .cfg_frame_len    (cfg_frame_len),
    .cfg_ifg          (cfg_ifg),
    .cfg_dport_lo     (cfg_dport_lo),
    .cfg_dport_hi     (cfg_dport_hi),
    .cfg_saddr_base   (cfg_saddr_base),
    .cfg_saddr_count  (cfg_saddr_count),
    .s_axis_tx_tready (s_axis_tx_tready),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tuser  (s_axis_tx_tuser),
    .pkt_count        (pkt_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  fb [0:2047];
  logic        m_first;
  logic [15:0] m_dport_next;
  int          m_sidx;
  int          m_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l < 64) ? 64 : ((l > 1518) ? 1518 : l);
  endfunction

  task automatic model_reset();
    m_first      = 1'b1;
    m_dport_next = 16'd0;
    m_sidx       = 0;
    m_pkt        = 0;
  endtask

  task automatic do_reset();
    sys_rst    = 1'b1;
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk156);
    sys_rst = 1'b0;
    model_reset();
  endtask

  // Build the expected wire bytes of one frame of length L.
  task automatic build_frame(input int L, input logic [15:0] d, input logic [31:0] s);
    int unsigned sum;
    logic [15:0] ck;
    for (int i = 0; i < 2048; i++) fb[i] = 8'h00;
    {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]}    = 48'h90E2BA5D8DC8;
    {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]}  = 48'h00BB00BB00BB;
    {fb[12], fb[13]} = 16'h0800;
    fb[14] = 8'h45;
    {fb[16], fb[17]} = 16'(L - 14);
    fb[22] = 8'd64;
    fb[23] = 8'd17;
    {fb[26], fb[27], fb[28], fb[29]} = s;
    {fb[30], fb[31], fb[32], fb[33]} = 32'h0A000001;
    {fb[34], fb[35]} = 16'd53;
    {fb[36], fb[37]} = d;
    {fb[38], fb[39]} = 16'(L - 34);
    fb[44] = 8'h80;
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {16'h0000, fb[14+2*i], fb[15+2*i]};
    while ((sum >> 16) != 0) sum = (sum & 32'h0000FFFF) + (sum >> 16);
    ck = ~16'(sum);
    {fb[24], fb[25]} = ck;
  endtask

  // Receive one frame, checking every presented beat; dead = idle cycles before it.
  task automatic recv_frame(input int len_cfg, input logic [15:0] d, input logic [31:0] s,
                            input bit rnd, input int drop_at, output int dead);
    int L, n, k, guard, nb;
    logic [63:0] exp_d, obs_d, pd;
    logic [7:0]  exp_k, pk;
    logic        pl;
    bit          stalled, done;
    L = clamp_len(len_cfg);
    n = (L + 7) / 8;
    build_frame(L, d, s);
    dead = 0;
    @(negedge clk156);
    while (!s_axis_tx_tvalid && dead < 3000) begin
      dead++;
      @(negedge clk156);
    end
    check("frame_start", 64'(s_axis_tx_tvalid), 64'd1);
    if (!s_axis_tx_tvalid) return;
    k = 0; stalled = 0; done = 0; guard = 0;
    pd = '0; pk = '0; pl = 1'b0;
    while (!done) begin
      check("tvalid_in_frame", 64'(s_axis_tx_tvalid), 64'd1);
      if (!s_axis_tx_tvalid) return;
      if (stalled) begin
        check("stall_data", s_axis_tx_tdata, pd);
        check("stall_keep", 64'(s_axis_tx_tkeep), 64'(pk));
        check("stall_last", 64'(s_axis_tx_tlast), 64'(pl));
      end
      nb = (L - 8*k >= 8) ? 8 : L - 8*k;
      exp_d = '0; obs_d = '0;
      for (int j = 0; j < nb; j++) begin
        exp_d[8*j +: 8] = fb[8*k + j];
        obs_d[8*j +: 8] = s_axis_tx_tdata[8*j +: 8];
      end
      exp_k = (k == n-1) ? (((L % 8) == 0) ? 8'hFF : 8'((1 << (L % 8)) - 1)) : 8'hFF;
      check($sformatf("beat%0d_data", k), obs_d, exp_d);
      check($sformatf("beat%0d_keep", k), 64'(s_axis_tx_tkeep), 64'(exp_k));
      check($sformatf("beat%0d_last", k), 64'(s_axis_tx_tlast), 64'(k == n-1));
      pd = s_axis_tx_tdata; pk = s_axis_tx_tkeep; pl = s_axis_tx_tlast;
      s_axis_tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axis_tx_tready) begin
        stalled = 0;
        if (k == drop_at) cfg_enable = 1'b0;
        if (k == n-1) done = 1;
        else k++;
      end else begin
        stalled = 1;
      end
      guard++;
      if (guard > 5000) begin
        check("frame_timeout", 64'd0, 64'd1);
        return;
      end
      if (!done) @(negedge clk156);
    end
  endtask

  // Predict dport/saddr for the next frame, receive it, then advance the model.
  task automatic expect_frame(input bit rnd, input int drop_at, output int dead);
    logic [15:0] d;
    logic [31:0] s;
    int          cnt;
    cnt = (cfg_saddr_count == 16'd0) ? 1 : int'(cfg_saddr_count);
    d   = m_first ? cfg_dport_lo : m_dport_next;
    s   = cfg_saddr_base + 32'(m_sidx);
    recv_frame(int'(cfg_frame_len), d, s, rnd, drop_at, dead);
    m_first      = 1'b0;
    m_dport_next = ((cfg_dport_lo > cfg_dport_hi) || (d == cfg_dport_hi)) ? cfg_dport_lo : d + 16'd1;
    m_sidx       = (m_sidx == cnt - 1) ? 0 : m_sidx + 1;
    m_pkt++;
  endtask

  task automatic check_count(input string tag);
    repeat (4) @(negedge clk156);
    check(tag, 64'(pkt_count), 64'(m_pkt));
  endtask

  initial begin
    int dead, seen, guard;
    int lens [4] = '{1020, 65, 40, 2000};

    // reset values, during and after reset
    model_reset();
    repeat (3) @(negedge clk156);
    check("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rst_tlast", 64'(s_axis_tx_tlast), 64'd0);
    check("rst_tkeep", 64'(s_axis_tx_tkeep), 64'd0);
    check("rst_tdata", s_axis_tx_tdata, 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    sys_rst = 1'b0;
    @(negedge clk156);
    check("idle_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("tuser", 64'(s_axis_tx_tuser), 64'd0);

    // minimum frame, back to back, pool size 0 treated as 1
    cfg_frame_len = 16'd64; cfg_ifg = '0; cfg_saddr_count = 16'd0;
    cfg_saddr_base = $urandom;
    cfg_enable = 1'b1;
    expect_frame(0, -1, dead);
    expect_frame(0, -1, dead);
    cfg_enable = 1'b0;
    check("ifg0_dead_cycles", 64'(dead), 64'd3);
    check_count("pkt_count_t1");

    // length edge cases and clamping
    for (int i = 0; i < 4; i++) begin
      cfg_frame_len = 16'(lens[i]);
      cfg_enable = 1'b1;
      expect_frame(0, -1, dead);
      cfg_enable = 1'b0;
    end
    check_count("pkt_count_t2");

    // random lengths with random back-pressure, lo > hi dport range
    do_reset();
    cfg_dport_lo = 16'd7000; cfg_dport_hi = 16'd6000; cfg_saddr_count = 16'd3;
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_frame_len = 16'($urandom_range(30, 1600));
      expect_frame(1, -1, dead);
    end
    cfg_enable = 1'b0;
    check_count("pkt_count_t3");

    // dport range sweep and saddr pool of two
    do_reset();
    cfg_dport_lo = 16'd50001; cfg_dport_hi = 16'd50003; cfg_saddr_count = 16'd2;
    cfg_saddr_base = $urandom;
    cfg_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cfg_frame_len = 16'($urandom_range(64, 200));
      expect_frame(1, -1, dead);
    end
    cfg_enable = 1'b0;
    s_axis_tx_tready = 1'b1;
    check_count("pkt_count_t4");
    check("pkt_count_seven", 64'(pkt_count), 64'd7);

    // reset in the middle of a frame
    cfg_frame_len = 16'd200;
    cfg_enable = 1'b1;
    guard = 0;
    @(negedge clk156);
    while (!s_axis_tx_tvalid && guard < 100) begin
      guard++;
      @(negedge clk156);
    end
    repeat (10) @(negedge clk156);
    check("pre_rst_tvalid", 64'(s_axis_tx_tvalid), 64'd1);
    sys_rst = 1'b1;
    @(negedge clk156);
    check("midrst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("midrst_tlast", 64'(s_axis_tx_tlast), 64'd0);
    check("midrst_pkt_count", 64'(pkt_count), 64'd0);
    sys_rst = 1'b0;
    model_reset();
    expect_frame(0, -1, dead);
    cfg_enable = 1'b0;
    check_count("pkt_count_t6");

    // inter-frame gap and enable dropped mid-frame
    do_reset();
    cfg_frame_len = 16'd64; cfg_ifg = 28'd100;
    cfg_enable = 1'b1;
    expect_frame(0, -1, dead);
    expect_frame(0, -1, dead);
    check("ifg100_dead_cycles", 64'(dead), 64'd103);
    cfg_ifg = 28'd7;
    expect_frame(0, -1, dead);
    expect_frame(0, -1, dead);
    check("ifg7_dead_cycles", 64'(dead), 64'd10);
    cfg_frame_len = 16'd200;
    expect_frame(0, 3, dead);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk156);
      if (s_axis_tx_tvalid) seen++;
    end
    check("no_tvalid_after_disable", 64'(seen), 64'd0);
    check("pkt_count_t5", 64'(pkt_count), 64'(m_pkt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
